// File: rtl/fpmult_issue_if.sv
// Issue/collect handshake bundle: operand stream in, multiplier taps, tagged result stream out.
// slave is the issue stage's view, master is the driving/consuming environment.
interface fpmult_issue_if #(
   parameter int TAGW = 4
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_a;
   logic [31:0]     in_b;
   logic [TAGW-1:0] in_tag;
   logic [31:0]     mul_a;
   logic [31:0]     mul_b;
   logic [31:0]     mul_res;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_res;
   logic [TAGW-1:0] out_tag;
   logic            busy;

   modport slave (
      input  in_valid, in_a, in_b, in_tag, mul_res, out_ready,
      output in_ready, mul_a, mul_b, out_valid, out_res, out_tag, busy
   );

   modport master (
      output in_valid, in_a, in_b, in_tag, mul_res, out_ready,
      input  in_ready, mul_a, mul_b, out_valid, out_res, out_tag, busy
   );
endinterface

// File: rtl/fpmult_issue.sv
// Issue/collect wrapper around a free-running LAT-stage FP32 multiplier; result valid LAT edges after fire.
// Credits (outstanding < DEPTH) gate in_ready, so the result FIFO never overflows and the multiplier never stalls.
module fpmult_issue #(
   parameter int LAT   = 3,
   parameter int DEPTH = 4,
   parameter int TAGW  = 4
) (
   input  logic          clk,
   input  logic          rst,
   fpmult_issue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic            in_ready;
   logic            out_valid;
   logic            fire;
   logic            pop;
   logic            wr;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   count;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [LAT-1:0]  sr_vld;
   logic [TAGW-1:0] sr_tag  [LAT];
   logic [31:0]     res_mem [DEPTH];
   logic [TAGW-1:0] tag_mem [DEPTH];

   // Credits cover both in-flight and stored ops, so a full count blocks issue.
   assign in_ready  = (outstanding < CW'(DEPTH));
   assign out_valid = (count != '0);
   assign fire      = bus.in_valid & in_ready;
   assign pop       = out_valid & bus.out_ready;
   assign wr        = sr_vld[LAT-1];

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.mul_a     = fire ? bus.in_a : 32'h0;
   assign bus.mul_b     = fire ? bus.in_b : 32'h0;
   assign bus.out_res   = out_valid ? res_mem[rd_ptr] : 32'h0;
   assign bus.out_tag   = out_valid ? tag_mem[rd_ptr] : '0;
   assign bus.busy      = (outstanding != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         outstanding <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         sr_vld      <= '0;
      end else begin
         if (fire && !pop)
            outstanding <= outstanding + CW'(1);
         else if (pop && !fire)
            outstanding <= outstanding - CW'(1);

         sr_vld[0] <= fire;
         for (int k = 1; k < LAT; k++)
            sr_vld[k] <= sr_vld[k-1];

         if (wr && !pop)
            count <= count + CW'(1);
         else if (pop && !wr)
            count <= count - CW'(1);

         if (wr)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Payload storage carries no reset; validity comes from sr_vld and count.
   always_ff @(posedge clk) begin
      sr_tag[0] <= bus.in_tag;
      for (int k = 1; k < LAT; k++)
         sr_tag[k] <= sr_tag[k-1];
      if (wr) begin
         res_mem[wr_ptr] <= bus.mul_res;
         tag_mem[wr_ptr] <= sr_tag[LAT-1];
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(wr && count == CW'(DEPTH)));
endmodule

// File: tb/tb_fpmult_issue.sv
// Directed bench for fpmult_issue with a behavioural 3-stage FP32 multiplier model.
// Covers single-op latency, streaming, backpressure, full-credit boundary, zero operands and mid-flight reset.
module tb_fpmult_issue;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fpmult_issue_if #(.TAGW(4)) bus ();

   fpmult_issue #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Normal-number multiply, truncating; any zero operand gives +0.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [9:0]  e;
      logic [22:0] m;
      if (a[30:0] == 31'h0 || b[30:0] == 31'h0)
         return 32'h0;
      p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
      e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
      if (p[47]) begin
         m = p[46:24];
         e = e + 10'd1;
      end else begin
         m = p[45:23];
      end
      return {a[31] ^ b[31], e[7:0], m};
   endfunction

   logic [31:0] mp [3];
   always @(posedge clk) begin
      if (!rst) begin
         mp[0] <= 32'h0;
         mp[1] <= 32'h0;
         mp[2] <= 32'h0;
      end else begin
         mp[0] <= fmul(bus.mul_a, bus.mul_b);
         mp[1] <= mp[0];
         mp[2] <= mp[1];
      end
   end
   assign bus.mul_res = mp[2];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [7];

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] q_res [$];
   logic [3:0]  q_tag [$];
   logic [31:0] e_res [$];
   logic [3:0]  e_tag [$];

   // Results are captured on the negedge before the edge that pops them.
   always @(negedge clk) begin
      if (rst && bus.out_valid && bus.out_ready) begin
         q_res.push_back(bus.out_res);
         q_tag.push_back(bus.out_tag);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_a     = 32'h0;
      bus.in_b     = 32'h0;
      bus.in_tag   = 4'h0;
   endtask

   // Offers one op and returns just after the edge that accepts it.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                        output int stalls);
      logic acc;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_tag   = tag;
      stalls       = 0;
      do begin
         @(negedge clk);
         acc = bus.in_ready;
         if (!acc) stalls++;
         step();
      end while (!acc && stalls < 200);
      if (!acc) chk("issue_timeout", 32'(stalls), 32'(0));
   endtask

   task automatic expect_results(input string name, input int budget);
      int waited = 0;
      while (q_res.size() < e_res.size() && waited < budget) begin
         step();
         waited++;
      end
      repeat (3) step();
      chk({name, "_count"}, 32'(q_res.size()), 32'(e_res.size()));
      for (int i = 0; i < e_res.size() && i < q_res.size(); i++) begin
         chk({name, "_res"}, q_res[i], e_res[i]);
         chk({name, "_tag"}, 32'(q_tag[i]), 32'(e_tag[i]));
      end
      q_res.delete(); q_tag.delete(); e_res.delete(); e_tag.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks passed %0d of %0d", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      int st;
      int tot;
      int n;

      tbl[0] = '{32'h40000000, 32'h40400000, 4'd5, 32'h40C00000};
      tbl[1] = '{32'h00000000, 32'h3F800000, 4'd1, 32'h00000000};
      tbl[2] = '{32'h80000000, 32'h3F800000, 4'd2, 32'h00000000};
      tbl[3] = '{32'h3FC00000, 32'h3FC00000, 4'd3, 32'h40100000};
      tbl[4] = '{32'hC0000000, 32'h40400000, 4'd4, 32'hC0C00000};
      tbl[5] = '{32'h3F000000, 32'h40800000, 4'd6, 32'h40000000};
      tbl[6] = '{32'h3F800000, 32'h3F800000, 4'd7, 32'h3F800000};

      idle();
      bus.out_ready = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_out_res",   bus.out_res,        32'h0);
      chk("rst_out_tag",   32'(bus.out_tag),   32'h0);

      // Single ops, including both zero-operand cases.
      for (int i = 0; i < 7; i++) begin
         step();
         issue(tbl[i].a, tbl[i].b, tbl[i].tag, st);
         idle();
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!bus.out_valid && n < 20);
         chk("single_latency", 32'(n), 32'(LAT + 1));
         chk("single_res", bus.out_res, tbl[i].exp);
         chk("single_tag", 32'(bus.out_tag), 32'(tbl[i].tag));
         step();
         bus.out_ready = 1'b1;
         step();
         bus.out_ready = 1'b0;
         @(negedge clk);
         chk("single_drained", 32'(bus.out_valid), 32'd0);
      end
      q_res.delete(); q_tag.delete();

      // Streaming: the first pop lands one edge after the fourth fire, costing one credit bubble.
      step();
      bus.out_ready = 1'b1;
      tot = 0;
      for (int i = 0; i < 8; i++) begin
         issue(tbl[i % 7].a, tbl[i % 7].b, 4'(i + 8), st);
         tot += st;
         e_res.push_back(tbl[i % 7].exp);
         e_tag.push_back(4'(i + 8));
      end
      idle();
      chk("stream_stalls", 32'(tot), 32'd1);
      expect_results("stream", 60);
      chk("stream_idle_busy", 32'(bus.busy), 32'd0);

      // Backpressure: four fires fill the credits, the fifth op waits with operands held.
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         issue(tbl[k].a, tbl[k].b, 4'(k), st);
         e_res.push_back(tbl[k].exp);
         e_tag.push_back(4'(k));
      end
      bus.in_valid = 1'b1;
      bus.in_a     = tbl[4].a;
      bus.in_b     = tbl[4].b;
      bus.in_tag   = 4'd4;
      repeat (6) step();
      @(negedge clk);
      chk("bp_in_ready_low", 32'(bus.in_ready),  32'd0);
      chk("bp_mul_a_gated",  bus.mul_a,          32'h0);
      chk("bp_out_valid",    32'(bus.out_valid), 32'd1);
      chk("bp_busy",         32'(bus.busy),      32'd1);
      step();
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("full_before_pop", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      chk("full_credit_return", 32'(bus.in_ready), 32'd1);
      step();
      e_res.push_back(tbl[4].exp);
      e_tag.push_back(4'd4);
      issue(tbl[5].a, tbl[5].b, 4'd5, st);
      e_res.push_back(tbl[5].exp);
      e_tag.push_back(4'd5);
      idle();
      expect_results("bp", 60);

      // Write and pop on the same edge at count == DEPTH-1.
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         issue(tbl[k + 3].a, tbl[k + 3].b, 4'(k + 10), st);
         e_res.push_back(tbl[k + 3].exp);
         e_tag.push_back(4'(k + 10));
      end
      idle();
      step();
      step();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("wrpop_popped_one", 32'(q_res.size()), 32'd1);
      chk("wrpop_out_valid",  32'(bus.out_valid), 32'd1);
      step();
      bus.out_ready = 1'b1;
      expect_results("wrpop", 40);
      chk("wrpop_busy", 32'(bus.busy), 32'd0);

      // Reset with two results stored and two still in the multiplier.
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++)
         issue(tbl[k].a, tbl[k].b, 4'(k + 1), st);
      idle();
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mrst_busy",      32'(bus.busy),      32'd0);
      chk("mrst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("mrst_out_tag",   32'(bus.out_tag),   32'h0);
      step();
      q_res.delete(); q_tag.delete();
      bus.out_ready = 1'b1;
      repeat (10) step();
      chk("mrst_no_stale", 32'(q_res.size()), 32'd0);
      chk("mrst_busy_after", 32'(bus.busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
